// File: rtl/router_pkg.sv
// router_pkg: shared flit definitions for the router tx/rx ports.
// Flit = {type[29:28], body[27:0]}; head body = {dst, len, seq}.
package router_pkg;

  localparam int FLIT_W   = 30;
  localparam int PLD_W    = 28;
  localparam int TYPE_LSB = 28;
  localparam int DST_LSB  = 20;
  localparam int LEN_LSB  = 16;
  localparam int SEQ_LSB  = 0;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_HEAD     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef struct packed {
    logic [7:0]  dst;
    logic [3:0]  len;
    logic [15:0] seq;
  } hdr_t;

  function automatic logic [FLIT_W-1:0] mk_flit(
    flit_type_e       t,
    logic [PLD_W-1:0] body
  );
    return {t, body};
  endfunction

endpackage

// File: rtl/router_flit_tx_if.sv
// router_flit_tx_if: packet source, payload and router-side flit/credit
// signals. master = source/router side, slave = router_flit_tx.
interface router_flit_tx_if;
  import router_pkg::*;

  logic              pkt_valid;
  logic              pkt_ready;
  logic [7:0]        pkt_dst;
  logic [3:0]        pkt_len;
  logic              pld_valid;
  logic              pld_ready;
  logic [PLD_W-1:0]  pld_data;
  logic              flit_valid;
  logic [FLIT_W-1:0] flit_data;
  logic              credit_ret;

  modport master (
    output pkt_valid, pkt_dst, pkt_len,
    output pld_valid, pld_data, credit_ret,
    input  pkt_ready, pld_ready,
    input  flit_valid, flit_data
  );

  modport slave (
    input  pkt_valid, pkt_dst, pkt_len,
    input  pld_valid, pld_data, credit_ret,
    output pkt_ready, pld_ready,
    output flit_valid, flit_data
  );

endinterface

// File: rtl/credit_counter.sv
// credit_counter: up/down counter of free router buffer slots.
// Ports: clk, rst_n, inc (credit return), dec (flit sent), has_credit.
module credit_counter #(
  parameter int CREDITS = 4,
  parameter int CRED_W  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic has_credit
);

  localparam logic [CRED_W-1:0] MAX = CRED_W'(CREDITS);

  logic [CRED_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc, dec})
      2'b10: if (cnt_q != MAX) cnt_d = cnt_q + 1'b1;
      2'b01: if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= MAX;
    else        cnt_q <= cnt_d;
  end

  assign has_credit = (cnt_q != '0);

  // A return with every slot already free means the router
  // and this side disagree on buffer depth.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(inc && !dec && cnt_q == MAX)
  ) else $warning("credit_ret with counter full");

endmodule

// File: rtl/router_flit_tx.sv
// router_flit_tx: serializes packet descriptors + payload into
// head/body/tail flits under credit flow control. Ports: clk, rst_n, bus, busy.
module router_flit_tx #(
  parameter int FLIT_W  = router_pkg::FLIT_W,
  parameter int CREDITS = 4,
  parameter int CRED_W  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  router_flit_tx_if.slave bus,
  output logic            busy
);
  import router_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEAD,
    S_BODY
  } state_e;

  state_e            state_q, state_d;
  hdr_t              hdr_q, hdr_d;
  logic [15:0]       seq_q, seq_d;
  logic [3:0]        rem_q, rem_d;
  logic              flit_valid_q, flit_valid_d;
  logic [FLIT_W-1:0] flit_data_q, flit_data_d;

  logic has_credit;
  logic emit;
  logic pkt_hs;
  logic pld_hs;

  assign bus.pkt_ready = (state_q == S_IDLE);
  assign bus.pld_ready = (state_q == S_BODY) && has_credit;
  assign busy          = (state_q != S_IDLE);

  assign pkt_hs = bus.pkt_valid && bus.pkt_ready;
  assign pld_hs = bus.pld_valid && bus.pld_ready;

  assign bus.flit_valid = flit_valid_q;
  assign bus.flit_data  = flit_data_q;

  credit_counter #(
    .CREDITS (CREDITS),
    .CRED_W  (CRED_W)
  ) u_cred (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (bus.credit_ret),
    .dec        (emit),
    .has_credit (has_credit)
  );

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    seq_d        = seq_q;
    rem_d        = rem_q;
    flit_valid_d = 1'b0;
    flit_data_d  = flit_data_q;
    emit         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pkt_hs) begin
          hdr_d.dst = bus.pkt_dst;
          hdr_d.len = bus.pkt_len;
          hdr_d.seq = seq_q;
          seq_d     = seq_q + 16'd1;
          state_d   = S_HEAD;
        end
      end
      S_HEAD: begin
        if (has_credit) begin
          emit         = 1'b1;
          flit_valid_d = 1'b1;
          if (hdr_q.len == 4'd0) begin
            flit_data_d = mk_flit(FT_HEADTAIL, hdr_q);
            state_d     = S_IDLE;
          end else begin
            flit_data_d = mk_flit(FT_HEAD, hdr_q);
            rem_d       = hdr_q.len;
            state_d     = S_BODY;
          end
        end
      end
      S_BODY: begin
        if (pld_hs) begin
          emit         = 1'b1;
          flit_valid_d = 1'b1;
          rem_d        = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            flit_data_d = mk_flit(FT_TAIL, bus.pld_data);
            state_d     = S_IDLE;
          end else begin
            flit_data_d = mk_flit(FT_BODY, bus.pld_data);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hdr_q        <= '0;
      seq_q        <= '0;
      rem_q        <= '0;
      flit_valid_q <= 1'b0;
      flit_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      seq_q        <= seq_d;
      rem_q        <= rem_d;
      flit_valid_q <= flit_valid_d;
      flit_data_q  <= flit_data_d;
    end
  end

endmodule

// File: tb/tb_router_flit_tx.sv
// tb_router_flit_tx: directed vectors for router_flit_tx.
// Plays both packet source and router (credit returns).
`timescale 1ns/1ps
module tb_router_flit_tx;
  import router_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  router_flit_tx_if bus();

  router_flit_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [29:0] fq[$];

  always @(negedge clk)
    if (bus.flit_valid === 1'b1) fq.push_back(bus.flit_data);

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cred();
    return 32'(dut.u_cred.cnt_q);
  endfunction

  task automatic send_hdr(input logic [7:0] dst, input logic [3:0] len);
    bus.pkt_dst   = dst;
    bus.pkt_len   = len;
    bus.pkt_valid = 1'b1;
    tick();
    bus.pkt_valid = 1'b0;
  endtask

  // len=0 packet; returns the single flit, then hands back its credit.
  task automatic send0(input logic [7:0] dst, output logic [29:0] f);
    bit got;
    got = 1'b0;
    f   = '0;
    send_hdr(dst, 4'd0);
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (bus.flit_valid === 1'b1) begin
        got = 1'b1;
        f   = bus.flit_data;
      end
    end
    if (!got) check("hdr_timeout", 32'd0, 32'd1);
    bus.credit_ret = 1'b1;
    tick();
    bus.credit_ret = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] f;
    bus.pkt_valid  = 1'b0;
    bus.pkt_dst    = '0;
    bus.pkt_len    = '0;
    bus.pld_valid  = 1'b0;
    bus.pld_data   = '0;
    bus.credit_ret = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_fv",   32'(bus.flit_valid), 32'd0);
    check("rst_fd",   32'(bus.flit_data),  32'd0);
    check("rst_prdy", 32'(bus.pkt_ready),  32'd1);
    check("rst_lrdy", 32'(bus.pld_ready),  32'd0);
    check("rst_busy", 32'(busy),           32'd0);
    check("rst_cred", cred(),              32'd4);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single-flit packet
    send_hdr(8'h5A, 4'd0);
    bus.pkt_dst = 8'hEE;
    check("t1_busy",   32'(busy),           32'd1);
    check("t1_fv_pre", 32'(bus.flit_valid), 32'd0);
    tick();
    check("t1_flit",   32'(bus.flit_data),  32'h35A0_0000);
    check("t1_fv",     32'(bus.flit_valid), 32'd1);
    check("t1_idle",   32'(busy),           32'd0);
    tick();
    check("t1_fv_drop", 32'(bus.flit_valid), 32'd0);
    check("t1_hold",    32'(bus.flit_data),  32'h35A0_0000);
    check("t1_cred",    cred(),              32'd3);
    bus.credit_ret = 1'b1;
    tick();
    bus.credit_ret = 1'b0;
    check("t1_cred_ret", cred(), 32'd4);

    // three-word packet
    send_hdr(8'h01, 4'd3);
    bus.pkt_len   = 4'hF;
    bus.pld_valid = 1'b1;
    bus.pld_data  = 28'hAAAAAAA;
    check("t2_lrdy_head", 32'(bus.pld_ready), 32'd0);
    tick();
    check("t2_head",  32'(bus.flit_data),  32'h1013_0001);
    check("t2_fv0",   32'(bus.flit_valid), 32'd1);
    check("t2_lrdy",  32'(bus.pld_ready),  32'd1);
    tick();
    check("t2_body0", 32'(bus.flit_data),  32'h0AAA_AAAA);
    check("t2_fv1",   32'(bus.flit_valid), 32'd1);
    bus.pld_data = 28'h1234567;
    tick();
    check("t2_body1", 32'(bus.flit_data),  32'h0123_4567);
    check("t2_fv2",   32'(bus.flit_valid), 32'd1);
    bus.pld_data = 28'hFFFFFFF;
    tick();
    check("t2_tail",  32'(bus.flit_data),  32'h2FFF_FFFF);
    check("t2_fv3",   32'(bus.flit_valid), 32'd1);
    check("t2_prdy",  32'(bus.pkt_ready),  32'd1);
    bus.pld_valid = 1'b0;
    tick();
    check("t2_fv_drop", 32'(bus.flit_valid), 32'd0);
    check("t2_hold",    32'(bus.flit_data),  32'h2FFF_FFFF);
    check("t2_cred0",   cred(),              32'd0);
    bus.credit_ret = 1'b1;
    repeat (4) tick();
    bus.credit_ret = 1'b0;
    check("t2_cred4", cred(), 32'd4);

    // credit exhaustion
    fq.delete();
    send_hdr(8'h22, 4'd7);
    bus.pld_valid = 1'b1;
    bus.pld_data  = 28'h00000C3;
    repeat (10) tick();
    check("t3_nflit4",  32'(fq.size()),      32'd4);
    check("t3_stall",   32'(bus.pld_ready),  32'd0);
    check("t3_busy",    32'(busy),           32'd1);
    bus.credit_ret = 1'b1;
    tick();
    bus.credit_ret = 1'b0;
    check("t3_rel_rdy", 32'(bus.pld_ready),  32'd1);
    check("t3_rel_fv0", 32'(bus.flit_valid), 32'd0);
    tick();
    check("t3_rel_fv",  32'(bus.flit_valid), 32'd1);
    check("t3_rel_fd",  32'(bus.flit_data),  32'h0000_00C3);
    check("t3_rel_stl", 32'(bus.pld_ready),  32'd0);
    repeat (3) tick();
    check("t3_nflit5",  32'(fq.size()),      32'd5);
    bus.credit_ret = 1'b1;
    repeat (4) tick();
    bus.credit_ret = 1'b0;
    bus.pld_valid  = 1'b0;
    check("t3_tail",    32'(bus.flit_data),  32'h2000_00C3);
    check("t3_done",    32'(busy),           32'd0);
    tick();
    check("t3_nflit8",  32'(fq.size()),      32'd8);
    check("t3_cred1",   cred(),              32'd1);
    bus.credit_ret = 1'b1;
    repeat (3) tick();
    bus.credit_ret = 1'b0;
    check("t3_cred4",   cred(),              32'd4);

    // simultaneous emit + credit_ret, then saturation
    send_hdr(8'h44, 4'd2);
    bus.pld_valid = 1'b1;
    bus.pld_data  = 28'h1111111;
    tick();
    check("t4_cred3", cred(), 32'd3);
    tick();
    check("t4_cred2", cred(), 32'd2);
    check("t4_body",  32'(bus.flit_data), 32'h0111_1111);
    bus.credit_ret = 1'b1;
    tick();
    check("t4_emit_ret", cred(),              32'd2);
    check("t4_tail",     32'(bus.flit_data),  32'h2111_1111);
    bus.pld_valid = 1'b0;
    repeat (2) tick();
    check("t4_full", cred(), 32'd4);
    tick();
    bus.credit_ret = 1'b0;
    check("t4_sat",  cred(), 32'd4);

    // sequence wrap
    force dut.seq_q = 16'hFFFF;
    tick();
    release dut.seq_q;
    send0(8'hC3, f);
    check("t5_seq_ffff", 32'(f), 32'h3C30_FFFF);
    send0(8'h3C, f);
    check("t5_seq_0000", 32'(f), 32'h33C0_0000);

    // reset mid-packet
    send_hdr(8'h99, 4'd3);
    bus.pld_valid = 1'b1;
    bus.pld_data  = 28'h0BEEF00;
    tick();
    tick();
    bus.pld_data = 28'h0CAFE00;
    tick();
    check("t6_body2",  32'(bus.flit_data),  32'h00CA_FE00);
    check("t6_fv_pre", 32'(bus.flit_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_fv_rst", 32'(bus.flit_valid), 32'd0);
    check("t6_fd_rst", 32'(bus.flit_data),  32'd0);
    check("t6_busy",   32'(busy),           32'd0);
    check("t6_lrdy",   32'(bus.pld_ready),  32'd0);
    bus.pld_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_prdy", 32'(bus.pkt_ready), 32'd1);
    check("t6_cred", cred(),             32'd4);
    send0(8'h77, f);
    check("t6_seq0", 32'(f), 32'h3770_0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
